// File: rtl/riscv_pkg.sv
// Shared encodings and helpers for the ALU issue/writeback slice.
// Holds opcode/funct7 constants, the issue FSM state type and the legality check.
package riscv_pkg;

  localparam logic [6:0] OPCODE_OP     = 7'b0110011;
  localparam logic [6:0] OPCODE_OP_IMM = 7'b0010011;

  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  typedef enum logic {
    IDLE = 1'b0,
    EXEC = 1'b1
  } state_t;

  // Anything that is not OP or OP-IMM falls through to illegal.
  function automatic logic instr_legal(
    input logic [6:0] opcode,
    input logic [2:0] funct3,
    input logic [6:0] funct7,
    input bit         muldiv
  );
    logic ok;
    ok = 1'b0;
    if (opcode == OPCODE_OP) begin
      ok = (funct7 == F7_BASE) ||
           ((funct7 == F7_ALT) && ((funct3 == 3'd0) || (funct3 == 3'd5))) ||
           ((funct7 == F7_MULDIV) && muldiv);
    end else if (opcode == OPCODE_OP_IMM) begin
      if (funct3 == 3'd1)      ok = (funct7 == F7_BASE);
      else if (funct3 == 3'd5) ok = (funct7 == F7_BASE) || (funct7 == F7_ALT);
      else                     ok = 1'b1;
    end
    return ok;
  endfunction

endpackage

// File: rtl/riscv_regfile.sv
// 32-entry integer register file: two async read ports, one sync write port.
// x0 always reads as zero and every entry clears on synchronous reset.
module riscv_regfile
  import riscv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [4:0]      rs1_addr,
  input  logic [4:0]      rs2_addr,
  output logic [XLEN-1:0] rs1_data,
  output logic [XLEN-1:0] rs2_data,
  input  logic            wr_en,
  input  logic [4:0]      wr_addr,
  input  logic [XLEN-1:0] wr_data
);

  logic [XLEN-1:0] regs [32];

  // NOTE: this array is reset explicitly because the architecture requires a
  // cleared register file after reset; that keeps it out of block RAM.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else if (wr_en && (wr_addr != 5'd0)) begin
      regs[wr_addr] <= wr_data;
    end
  end

  assign rs1_data = (rs1_addr == 5'd0) ? '0 : regs[rs1_addr];
  assign rs2_data = (rs2_addr == 5'd0) ? '0 : regs[rs2_addr];

endmodule

// File: rtl/riscv_alu_issue.sv
// Issue/writeback stage around the integer ALU: latches an instruction, decodes
// OP/OP-IMM, drives the ALU from the register file and retires its result.
module riscv_alu_issue
  import riscv_pkg::*;
#(
  parameter bit MULDIV = 1'b1,
  parameter int XLEN   = 32
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            instr_valid,
  input  logic [31:0]     instr,
  output logic            instr_ready,
  output logic            alu_enabled,
  output logic            is_op_alu,
  output logic            is_op_alu_imm,
  output logic [2:0]      op_funct3,
  output logic [6:0]      op_funct7,
  output logic [XLEN-1:0] reg_s1,
  output logic [XLEN-1:0] reg_s2,
  output logic [XLEN-1:0] imm,
  input  logic [XLEN-1:0] rd_alu,
  input  logic            is_alu_wait,
  output logic            retire_valid,
  output logic [4:0]      retire_rd,
  output logic [XLEN-1:0] retire_data,
  output logic            illegal_instr
);

  state_t      state;
  logic [31:0] ir;

  logic [6:0]      opcode;
  logic [4:0]      rd;
  logic [2:0]      funct3;
  logic [6:0]      funct7;
  logic            legal;
  logic            exec;
  logic            complete;
  logic [XLEN-1:0] rs1_data;
  logic [XLEN-1:0] rs2_data;

  assign opcode = ir[6:0];
  assign rd     = ir[11:7];
  assign funct3 = ir[14:12];
  assign funct7 = ir[31:25];
  assign legal  = instr_legal(opcode, funct3, funct7, MULDIV);

  assign exec        = (state == EXEC);
  assign complete    = exec && !is_alu_wait;
  assign instr_ready = !exec || !is_alu_wait;

  // The regfile only changes at completion, so reads stay stable while stalled.
  riscv_regfile #(.XLEN(XLEN)) u_regfile (
    .clock    (clock),
    .reset    (reset),
    .rs1_addr (ir[19:15]),
    .rs2_addr (ir[24:20]),
    .rs1_data (rs1_data),
    .rs2_data (rs2_data),
    .wr_en    (complete && legal),
    .wr_addr  (rd),
    .wr_data  (rd_alu)
  );

  // NOTE: every output gets a default first so no path through this block
  // leaves a value unassigned, which would otherwise infer a latch.
  always_comb begin
    alu_enabled   = 1'b0;
    is_op_alu     = 1'b0;
    is_op_alu_imm = 1'b0;
    op_funct3     = '0;
    op_funct7     = '0;
    reg_s1        = '0;
    reg_s2        = '0;
    imm           = '0;
    if (exec) begin
      alu_enabled   = legal;
      is_op_alu     = legal && (opcode == OPCODE_OP);
      is_op_alu_imm = legal && (opcode == OPCODE_OP_IMM);
      op_funct3     = funct3;
      op_funct7     = funct7;
      reg_s1        = rs1_data;
      reg_s2        = rs2_data;
      imm           = {{(XLEN-12){ir[31]}}, ir[31:20]};
    end
  end

  // NOTE: state and registered outputs use non-blocking assignments so every
  // flop samples pre-edge values regardless of statement order.
  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= IDLE;
      ir            <= '0;
      retire_valid  <= 1'b0;
      retire_rd     <= '0;
      retire_data   <= '0;
      illegal_instr <= 1'b0;
    end else begin
      retire_valid  <= complete;
      illegal_instr <= complete && !legal;
      if (complete) begin
        retire_rd   <= rd;
        retire_data <= legal ? rd_alu : '0;
      end
      unique case (state)
        IDLE: begin
          if (instr_valid) begin
            ir    <= instr;
            state <= EXEC;
          end
        end
        EXEC: begin
          // Accepting at completion chains straight into the next EXEC.
          if (!is_alu_wait) begin
            if (instr_valid) ir <= instr;
            else             state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_riscv_alu_issue.sv
// Directed bench for riscv_alu_issue: hand-computed vectors for decode, chaining,
// stalls, illegal encodings, x0 handling and reset mid-operation.
module tb_riscv_alu_issue;

  logic        clock = 1'b0;
  logic        reset = 1'b1;

  logic        instr_valid = 1'b0;
  logic [31:0] instr       = '0;
  logic [31:0] rd_alu      = '0;
  logic        is_alu_wait = 1'b0;
  logic        instr_ready, alu_enabled, is_op_alu, is_op_alu_imm;
  logic [2:0]  op_funct3;
  logic [6:0]  op_funct7;
  logic [31:0] reg_s1, reg_s2, imm, retire_data;
  logic        retire_valid, illegal_instr;
  logic [4:0]  retire_rd;

  logic        n_valid = 1'b0;
  logic [31:0] n_instr = '0;
  logic [31:0] n_rd_alu = '0;
  logic        n_wait = 1'b0;
  logic        n_ready, n_alu_en, n_is_op, n_is_imm;
  logic [2:0]  n_funct3;
  logic [6:0]  n_funct7;
  logic [31:0] n_s1, n_s2, n_imm, n_ret_data;
  logic        n_ret_valid, n_illegal;
  logic [4:0]  n_ret_rd;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clock = ~clock;

  riscv_alu_issue #(.MULDIV(1'b1), .XLEN(32)) dut (
    .clock(clock), .reset(reset), .instr_valid(instr_valid), .instr(instr),
    .instr_ready(instr_ready), .alu_enabled(alu_enabled), .is_op_alu(is_op_alu),
    .is_op_alu_imm(is_op_alu_imm), .op_funct3(op_funct3), .op_funct7(op_funct7),
    .reg_s1(reg_s1), .reg_s2(reg_s2), .imm(imm), .rd_alu(rd_alu),
    .is_alu_wait(is_alu_wait), .retire_valid(retire_valid), .retire_rd(retire_rd),
    .retire_data(retire_data), .illegal_instr(illegal_instr)
  );

  riscv_alu_issue #(.MULDIV(1'b0), .XLEN(32)) dut_nomd (
    .clock(clock), .reset(reset), .instr_valid(n_valid), .instr(n_instr),
    .instr_ready(n_ready), .alu_enabled(n_alu_en), .is_op_alu(n_is_op),
    .is_op_alu_imm(n_is_imm), .op_funct3(n_funct3), .op_funct7(n_funct7),
    .reg_s1(n_s1), .reg_s2(n_s2), .imm(n_imm), .rd_alu(n_rd_alu),
    .is_alu_wait(n_wait), .retire_valid(n_ret_valid), .retire_rd(n_ret_rd),
    .retire_data(n_ret_data), .illegal_instr(n_illegal)
  );

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_cmp++;
    assert (observed === expected)
    else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  // Inputs change 1 ns after the rising edge; outputs are sampled 1 ns later.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    // ---- reset ----
    tick(); tick();
    reset = 1'b0;
    settle();
    check("rst_ready", 32'(instr_ready), 32'd1);
    check("rst_retire", 32'(retire_valid), 32'd0);
    check("rst_alu_en", 32'(alu_enabled), 32'd0);
    check("rst_funct3", 32'(op_funct3), 32'd0);
    check("rst_s1", reg_s1, 32'd0);

    // ---- addi x1,x0,5 ----
    instr_valid = 1'b1; instr = 32'h0050_0093;
    tick();
    instr_valid = 1'b0; rd_alu = 32'd5; is_alu_wait = 1'b0;
    settle();
    check("addi_is_imm", 32'(is_op_alu_imm), 32'd1);
    check("addi_is_op", 32'(is_op_alu), 32'd0);
    check("addi_imm", imm, 32'd5);
    check("addi_alu_en", 32'(alu_enabled), 32'd1);
    tick();
    check("addi_ret_valid", 32'(retire_valid), 32'd1);
    check("addi_ret_rd", 32'(retire_rd), 32'd1);
    check("addi_ret_data", retire_data, 32'd5);
    check("addi_illegal", 32'(illegal_instr), 32'd0);

    // ---- addi x2,x0,-3 ----
    instr_valid = 1'b1; instr = 32'hFFD0_0113;
    tick();
    instr_valid = 1'b0; rd_alu = 32'hFFFF_FFFD;
    settle();
    check("neg_imm", imm, 32'hFFFF_FFFD);
    tick();
    check("neg_ret_rd", 32'(retire_rd), 32'd2);

    // ---- add x3,x1,x2 chained into sub x3,x1,x2 ----
    instr_valid = 1'b1; instr = 32'h0020_81B3;
    tick();
    instr = 32'h4020_81B3; rd_alu = 32'd2;
    settle();
    check("add_ready", 32'(instr_ready), 32'd1);
    check("add_s1", reg_s1, 32'd5);
    check("add_s2", reg_s2, 32'hFFFF_FFFD);
    check("add_funct7", 32'(op_funct7), 32'h00);
    check("add_is_op", 32'(is_op_alu), 32'd1);
    tick();
    check("add_ret_valid", 32'(retire_valid), 32'd1);
    check("add_ret_rd", 32'(retire_rd), 32'd3);
    check("add_ret_data", retire_data, 32'd2);
    instr_valid = 1'b0; rd_alu = 32'd8;
    settle();
    check("sub_ready", 32'(instr_ready), 32'd1);
    check("sub_s1", reg_s1, 32'd5);
    check("sub_s2", reg_s2, 32'hFFFF_FFFD);
    check("sub_funct7", 32'(op_funct7), 32'h20);
    tick();
    check("sub_ret_valid", 32'(retire_valid), 32'd1);
    check("sub_ret_rd", 32'(retire_rd), 32'd3);
    check("sub_ret_data", retire_data, 32'd8);

    // ---- mul x4,x1,x2 with a 10-cycle stall; a competing instr must be refused ----
    instr_valid = 1'b1; instr = 32'h0220_8233;
    tick();
    instr = 32'h0070_0013; is_alu_wait = 1'b1; rd_alu = 32'hDEAD_BEEF;
    for (int i = 0; i < 10; i++) begin
      settle();
      check("mul_wait_ready", 32'(instr_ready), 32'd0);
      check("mul_wait_s1", reg_s1, 32'd5);
      check("mul_wait_s2", reg_s2, 32'hFFFF_FFFD);
      check("mul_wait_f7", 32'(op_funct7), 32'h01);
      check("mul_wait_f3", 32'(op_funct3), 32'd0);
      check("mul_wait_alu_en", 32'(alu_enabled), 32'd1);
      check("mul_wait_is_op", 32'(is_op_alu), 32'd1);
      check("mul_wait_retire", 32'(retire_valid), 32'd0);
      tick();
    end
    instr_valid = 1'b0; is_alu_wait = 1'b0; rd_alu = 32'hFFFF_FFF1;
    settle();
    check("mul_done_ready", 32'(instr_ready), 32'd1);
    tick();
    check("mul_ret_valid", 32'(retire_valid), 32'd1);
    check("mul_ret_rd", 32'(retire_rd), 32'd4);
    check("mul_ret_data", retire_data, 32'hFFFF_FFF1);
    tick();
    check("mul_single_retire", 32'(retire_valid), 32'd0);

    // ---- lw x1,0(x1): illegal, no write ----
    instr_valid = 1'b1; instr = 32'h0000_A083;
    tick();
    instr_valid = 1'b0; rd_alu = 32'h0000_1234;
    settle();
    check("lw_alu_en", 32'(alu_enabled), 32'd0);
    check("lw_is_op", 32'(is_op_alu), 32'd0);
    check("lw_is_imm", 32'(is_op_alu_imm), 32'd0);
    tick();
    check("lw_illegal", 32'(illegal_instr), 32'd1);
    check("lw_ret_valid", 32'(retire_valid), 32'd1);
    check("lw_ret_data", retire_data, 32'd0);

    // ---- slli with funct7=0100000: illegal OP-IMM ----
    instr_valid = 1'b1; instr = 32'h4010_9093;
    tick();
    instr_valid = 1'b0; rd_alu = 32'h0000_0A0A;
    settle();
    check("slli_alt_alu_en", 32'(alu_enabled), 32'd0);
    tick();
    check("slli_alt_illegal", 32'(illegal_instr), 32'd1);
    check("slli_alt_ret_data", retire_data, 32'd0);

    // ---- x1 still 5 after the illegal writes ----
    instr_valid = 1'b1; instr = 32'h0020_81B3;
    tick();
    instr_valid = 1'b0; rd_alu = 32'd2;
    settle();
    check("x1_kept", reg_s1, 32'd5);
    tick();

    // ---- addi x0,x0,7: retires, no write ----
    instr_valid = 1'b1; instr = 32'h0070_0013;
    tick();
    instr_valid = 1'b0; rd_alu = 32'd7;
    tick();
    check("x0_ret_valid", 32'(retire_valid), 32'd1);
    check("x0_ret_rd", 32'(retire_rd), 32'd0);
    check("x0_ret_data", retire_data, 32'd7);
    check("x0_illegal", 32'(illegal_instr), 32'd0);
    instr_valid = 1'b1; instr = 32'h0000_02B3;
    tick();
    instr_valid = 1'b0; rd_alu = 32'd0;
    settle();
    check("x0_read_s1", reg_s1, 32'd0);
    check("x0_read_s2", reg_s2, 32'd0);
    tick();

    // ---- MULDIV=0 instance: mul is illegal ----
    n_valid = 1'b1; n_instr = 32'h0220_8233;
    tick();
    n_valid = 1'b0; n_rd_alu = 32'h5555_5555;
    settle();
    check("nomd_alu_en", 32'(n_alu_en), 32'd0);
    check("nomd_is_op", 32'(n_is_op), 32'd0);
    tick();
    check("nomd_illegal", 32'(n_illegal), 32'd1);
    check("nomd_ret_valid", 32'(n_ret_valid), 32'd1);
    check("nomd_ret_data", n_ret_data, 32'd0);

    // ---- reset during a mul stall, with a simultaneous instr_valid ----
    instr_valid = 1'b1; instr = 32'h0220_8233;
    tick();
    instr_valid = 1'b0; is_alu_wait = 1'b1; rd_alu = 32'h1111_1111;
    for (int i = 0; i < 4; i++) tick();
    settle();
    check("pre_rst_ready", 32'(instr_ready), 32'd0);
    reset = 1'b1; instr_valid = 1'b1; instr = 32'h0050_0093;
    tick();
    reset = 1'b0; instr_valid = 1'b0;
    settle();
    check("mid_rst_ready", 32'(instr_ready), 32'd1);
    check("mid_rst_alu_en", 32'(alu_enabled), 32'd0);
    check("mid_rst_retire", 32'(retire_valid), 32'd0);
    is_alu_wait = 1'b0;
    tick();
    check("mid_rst_no_retire", 32'(retire_valid), 32'd0);
    instr_valid = 1'b1; instr = 32'h0020_81B3;
    tick();
    instr_valid = 1'b0; rd_alu = 32'd0;
    settle();
    check("mid_rst_x1", reg_s1, 32'd0);
    check("mid_rst_x2", reg_s2, 32'd0);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/riscv_alu_issue.md
Name: riscv_alu_issue

Overview:
- Issue/writeback stage directly upstream and downstream of the integer ALU.
- Accepts one instruction word per handshake from fetch and decodes OP and OP-IMM.
- Reads the 32x32 register file and drives the ALU operand/opcode inputs.
- Holds those inputs stable while the ALU reports is_alu_wait, then writes rd_alu back to rd and reports the retirement.

Parameters:
- MULDIV, 1, accept funct7=0000001 on OP (M extension); 0 = such encodings are illegal.
- XLEN, 32, datapath width; only 32 supported.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high
- instr_valid  in  1  fetch presents instr
- instr  in  32  instruction word
- instr_ready  out  1  block accepts instr this cycle
- alu_enabled  out  1  ALU enable (high in EXEC)
- is_op_alu  out  1  OP class decoded
- is_op_alu_imm  out  1  OP-IMM class decoded
- op_funct3  out  3  instr[14:12]
- op_funct7  out  7  instr[31:25]
- reg_s1  out  32  x[rs1]
- reg_s2  out  32  x[rs2]
- imm  out  32  sign-extended I-immediate
- rd_alu  in  32  ALU result
- is_alu_wait  in  1  ALU needs more cycles
- retire_valid  out  1  one-cycle pulse: instruction completed
- retire_rd  out  5  destination index of retired instruction
- retire_data  out  32  value written, or 0 if illegal
- illegal_instr  out  1  one-cycle pulse, coincident with retire_valid

Behaviour:
- Reset: state=IDLE, IR=0, all x1..x31=0. Outputs go to 0 with instr_ready=1 (combinational from IDLE).
- States:
  - IDLE: instr_ready=1. On instr_valid, latch instr into IR and go to EXEC.
  - EXEC: decode is driven from IR. Regfile reads are combinational from IR[19:15] and IR[24:20].
- EXEC completion: a cycle with is_alu_wait=0.
  - If rd!=0 and the instruction is legal, write rd_alu into x[rd] at that edge.
  - Next cycle: retire_valid=1, retire_rd=rd, retire_data=rd_alu (value captured at completion).
- instr_ready = IDLE or (EXEC and !is_alu_wait).
  - Accepting at completion starts the next EXEC immediately, giving 1 instruction/cycle throughput for single-cycle ops.
  - No hazard: the regfile write lands at the same edge the new IR is loaded.
- Decode:
  - opcode 0110011 -> is_op_alu.
  - opcode 0010011 -> is_op_alu_imm.
  - imm = {{20{IR[31]}}, IR[31:20]}.
  - op_funct7 is passed raw for both classes.
- Legality:
  - OP: funct7=0000000 any funct3; 0100000 only with funct3 0 or 5; 0000001 only if MULDIV=1.
  - OP-IMM: funct3=1 requires funct7=0000000; funct3=5 requires funct7 0000000 or 0100000.
- Illegal instructions (including any other opcode):
  - is_op_alu, is_op_alu_imm and alu_enabled stay 0.
  - Complete in the EXEC cycle without any write.
  - Next cycle: illegal_instr=1, retire_valid=1, retire_data=0.
- x0: reads return 0; writes are suppressed but still retire with retire_rd=0 and retire_data=rd_alu.
- In EXEC while is_alu_wait=1: IR, decode outputs and reg_s1/reg_s2 are held bit-stable; instr_ready=0.
- alu_enabled, is_op_alu and is_op_alu_imm are 0 in IDLE, so the ALU sees funct3=0.
- Reset mid-operation (any state, including mid-multiply):
  - Next cycle is IDLE with regfile cleared.
  - No retire pulse for the aborted instruction.
  - The ALU shares the same reset.
- Simultaneous reset and instr_valid: reset wins; the instruction is not accepted.

Decomposition:
- Shared package riscv_pkg holds:
  - opcode constants OPCODE_OP=7'b0110011 and OPCODE_OP_IMM=7'b0010011;
  - funct7 constants F7_BASE, F7_ALT=7'b0100000, F7_MULDIV=7'b0000001;
  - state enum {IDLE, EXEC}.
- One sub-module: riscv_regfile, with 2 async read ports, 1 sync write port, x0 hardwired to 0, and synchronous reset clearing all entries.

Test Plan:
- reset, then instr 0x00500093 (addi x1,x0,5) with rd_alu=5, is_alu_wait=0 -> is_op_alu_imm=1, imm=5 in EXEC; next cycle retire_valid=1, retire_rd=1, retire_data=5; x1=5.
- Preload x1=5 and x2=0xFFFFFFFD (instr 0xFFD00113), then 0x002081B3 (add) followed back-to-back by 0x402081B3 (sub) -> instr_ready stays 1; reg_s1=5 and reg_s2=0xFFFFFFFD both cycles; op_funct7 0x00 then 0x20; two consecutive retire pulses with rd=3.
- 0x02208233 (mul x4,x1,x2) with is_alu_wait=1 for 10 cycles -> instr_ready=0 and all ALU inputs bit-stable for 10 cycles; a single retire with rd=4 one cycle after wait drops.
- 0x0000A083 (lw) -> alu_enabled=0; next cycle illegal_instr=1, retire_data=0; x1 unchanged. Repeat 0x02208233 with MULDIV=0 -> illegal.
- 0x00700013 (addi x0,x0,7) with rd_alu=7 -> retire_rd=0; subsequent read of x0 returns 0.
- Assert reset during the mul stall at cycle 4 -> next cycle IDLE, instr_ready=1, no retire pulse; x1=x2=0.
